// File: rtl/morse_decoder.sv
// morse_decoder: Morse digit receiver. It times each key press as a dot or
// a dash, collects five symbols and decodes them to a BCD digit.
// Ports: clk, reset (sync, active-high), key (1 = pressed);
//   m1..m5 captured symbols (1 = dot, m1 first), sym_cnt symbols so far,
//   digit/valid decoded result, red error (bad pattern or timeout).
// Optional build macro MORSE_DEBOUNCE_EN: key synchronizer + debounce.
module morse_decoder #(
  parameter int unsigned DOT_MAX    = 12_500_000,
  parameter int unsigned GAP_MAX    = 50_000_000,
  parameter int unsigned DEB_CYCLES = 500_000,
  parameter int unsigned CNT_W      = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  output logic       m1,
  output logic       m2,
  output logic       m3,
  output logic       m4,
  output logic       m5,
  output logic [2:0] sym_cnt,
  output logic [3:0] digit,
  output logic       valid,
  output logic       red
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);
  localparam logic [CNT_W-1:0] DOT_LIM =
    CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] DOT_SAT =
    CNT_W'(DOT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_MAX - 1);

  // The shared counter must represent every limit it is compared with.
  localparam longint unsigned CNT_LIM =
    64'd1 << CNT_W;

  if ((64'(DOT_MAX) + 64'd1) >= CNT_LIM ||
      64'(GAP_MAX) >= CNT_LIM ||
      64'(DEB_CYCLES) >= CNT_LIM)
  begin : g_bad_cnt_w
    $error("morse_decoder: CNT_W too narrow");
  end

  logic key_s;

`ifdef MORSE_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DEB_LAST =
    (DEB_CYCLES > 0) ? CNT_W'(DEB_CYCLES - 1)
                     : '0;

  logic [1:0]       sync_q;
  logic [1:0]       sync_d;
  logic             filt_q;
  logic             filt_d;
  logic [CNT_W-1:0] deb_q;
  logic [CNT_W-1:0] deb_d;

  // deb counts consecutive cycles the synced key disagrees with the
  // filter; any agreeing cycle restarts the stability window.
  always_comb begin
    sync_d = {sync_q[0], key};
    filt_d = filt_q;
    deb_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (deb_q >= DEB_LAST) begin
        filt_d = sync_q[1];
      end else begin
        deb_d = deb_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      deb_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      deb_q  <= deb_d;
    end
  end

  assign key_s = filt_q;
`else
  assign key_s = key;
`endif

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [4:0]       m_q;
  logic [4:0]       m_d;
  logic [2:0]       sym_cnt_q;
  logic [2:0]       sym_cnt_d;
  logic [3:0]       digit_q;
  logic [3:0]       digit_d;
  logic             valid_q;
  logic             valid_d;
  logic             red_q;
  logic             red_d;

  logic [4:0] pat;
  logic [4:0] dec;

  // Pattern written m1 first, so it reads like the code table.
  assign pat = {m_q[0], m_q[1], m_q[2],
                m_q[3], m_q[4]};

  // Result is {hit, value}.
  function automatic logic [4:0] decode(
    input logic [4:0] p
  );
    logic [4:0] r;
    case (p)
      5'b00000: r = {1'b1, 4'd0};
      5'b10000: r = {1'b1, 4'd1};
      5'b11000: r = {1'b1, 4'd2};
      5'b11100: r = {1'b1, 4'd3};
      5'b11110: r = {1'b1, 4'd4};
      5'b11111: r = {1'b1, 4'd5};
      5'b01111: r = {1'b1, 4'd6};
      5'b00111: r = {1'b1, 4'd7};
      5'b00011: r = {1'b1, 4'd8};
      5'b00001: r = {1'b1, 4'd9};
      default:  r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  assign dec = decode(pat);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_d       = m_q;
    sym_cnt_d = sym_cnt_q;
    digit_d   = digit_q;
    valid_d   = valid_q;
    red_d     = red_q;
    unique case (state_q)
      IDLE: begin
        if (key_s) begin
          state_d   = PRESS;
          cnt_d     = CNT_ONE;
          m_d       = '0;
          sym_cnt_d = '0;
          digit_d   = '0;
          valid_d   = 1'b0;
          red_d     = 1'b0;
        end
      end
      PRESS: begin
        if (key_s) begin
          // Saturate just past the dot limit.
          if (cnt_q < DOT_SAT) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          m_d[sym_cnt_q] = (cnt_q <= DOT_LIM);
          sym_cnt_d      = sym_cnt_q + 3'd1;
          if (sym_cnt_q == 3'd4) begin
            state_d = DONE;
          end else begin
            state_d = GAP;
            cnt_d   = CNT_ONE;
          end
        end
      end
      GAP: begin
        // The releasing cycle already counted as gap cycle 1.
        if (key_s) begin
          state_d = PRESS;
          cnt_d   = CNT_ONE;
        end else if (cnt_q >= GAP_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (sym_cnt_q == 3'd5 && dec[4]) begin
          digit_d = dec[3:0];
          valid_d = 1'b1;
          red_d   = 1'b0;
        end else begin
          digit_d = '0;
          valid_d = 1'b0;
          red_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      m_q       <= '0;
      sym_cnt_q <= '0;
      digit_q   <= '0;
      valid_q   <= 1'b0;
      red_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      sym_cnt_q <= sym_cnt_d;
      digit_q   <= digit_d;
      valid_q   <= valid_d;
      red_q     <= red_d;
    end
  end

  assign m1      = m_q[0];
  assign m2      = m_q[1];
  assign m3      = m_q[2];
  assign m4      = m_q[3];
  assign m5      = m_q[4];
  assign sym_cnt = sym_cnt_q;
  assign digit   = digit_q;
  assign valid   = valid_q;
  assign red     = red_q;

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Sequential Morse receiver for decimal digits: samples a single push-button key, classifies each press as dot or dash by its duration, collects the five symbols of a Morse digit, and decodes them to a 4-bit BCD value. It is the receive-side counterpart of the digit-to-Morse encoder on the board. Its symbol order and polarity match the encoder: m1 is sent first, 1 means dot, 0 means dash. It drives the digit display and the red error LED.

## Interface
- DOT_MAX, default 12_500_000: longest press, in cycles, still classified as a dot (0.25 s at 50 MHz).
- GAP_MAX, default 50_000_000: key-released cycles that abort an unfinished character.
- DEB_CYCLES, default 500_000: key stability window; used only with debounce compiled in.
- CNT_W, default 26: duration counter width; must hold max(DOT_MAX+1, GAP_MAX, DEB_CYCLES).
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- key  in  1  Morse key, 1 = pressed.
- m1..m5  out  1 each  captured symbols, 1 = dot; m1 is the first received.
- sym_cnt  out  3  number of symbols captured in the current character, 0..5.
- digit  out  4  decoded value 0..9.
- valid  out  1  digit holds a good decode.
- red  out  1  error: invalid pattern or timeout.

## Operation
- FSM states are IDLE, PRESS, GAP and DONE. Reset puts the FSM in IDLE with every output 0.
- **IDLE**
  - Previous results stay held.
  - key=1 → PRESS. On this transition the block clears valid, red, digit, m1..m5 and sym_cnt, and loads the counter with 1.
  - A key already held when reset releases counts as a press start.
- **PRESS**
  - Each cycle with key=1, the counter increments. It saturates at DOT_MAX+1 and never wraps.
  - key=0 ends the press. L is the counted length.
  - Symbol = 1 if L ≤ DOT_MAX, else 0. The symbol is written to m[sym_cnt+1], and sym_cnt increments.
  - If the new sym_cnt = 5 → DONE. Otherwise → GAP, with the counter loaded with 1.
- **GAP**
  - Each cycle with key=0, the counter increments.
  - key=1 → PRESS, counter loaded with 1.
  - Counter reaching GAP_MAX → DONE, with the character incomplete.
- **DONE** lasts exactly one cycle, then → IDLE.
  - m1..m5 decode as follows: 00000→0, 10000→1, 11000→2, 11100→3, 11110→4, 11111→5, 01111→6, 00111→7, 00011→8, 00001→9.
  - Match: digit = value, valid=1, red=0.
  - No match, or sym_cnt<5: digit=0, valid=0, red=1.
- Outputs then hold until the next character starts or reset.
- Reset mid-character discards all partial state in the same edge.

## Timing
- Without debounce, the key is sampled directly each cycle.
- Press classification:
  - Key falls and is first sampled 0 in cycle N.
  - The symbol and sym_cnt update at the end of N.
  - The FSM is in DONE (5th symbol) or GAP in cycle N+1.
- Result latency: digit, valid and red are registered at the end of N+1 and visible from N+2.
- Timeout: red becomes visible 2 cycles after GAP_MAX consecutive released cycles.
- A key sampled 1 while in DONE is ignored. A new character requires key=1 observed in IDLE.
- Reset takes priority over every transition.

## Configuration
- MORSE_DEBOUNCE_EN
- **Defined:**
  - key passes through a 2-flop synchronizer.
  - It then passes a filter whose output changes only after the synchronized input has been stable for DEB_CYCLES cycles.
  - The FSM uses the filtered signal, so all timing above is measured from the filtered edge. That adds DEB_CYCLES+2 cycles of latency.
  - Presses shorter than DEB_CYCLES are invisible.
  - The filter resets to 0.
- **Undefined:**
  - key feeds the FSM directly, with no synchronizer.
  - DEB_CYCLES is unused.

## Test plan
All scenarios use DOT_MAX=3, GAP_MAX=8, MORSE_DEBOUNCE_EN undefined.
- **Digit 5:** five 2-cycle presses separated by 2-cycle gaps → m1..m5=11111, digit=5, valid=1, red=0, 2 cycles after the last release.
- **Digit 7:** press lengths 6,6,2,2,2 → 00111, digit=7, valid=1; outputs hold through 20 idle cycles.
- **Threshold:** a 3-cycle press gives m1=1; a 4-cycle press gives m1=0. Five 4-cycle presses → digit=0, valid=1. A 100-cycle press gives a dash with no counter wrap.
- **Invalid pattern:** lengths 2,6,2,6,6 (10100) → red=1, valid=0, digit=0. The next press clears red.
- **Timeout:** two dots, then key low for 8 cycles → red=1, valid=0, sym_cnt=2 held.
- **Mid reset:** reset pulsed after 3 symbols → all outputs 0, FSM in IDLE. A following entry of digit 9 (lengths 6,6,6,6,2) decodes to digit=9, valid=1.
